// File: rtl/ctrl_pkg.sv
// Shared opcode/ALU constants, control-bundle struct and stage FSM states
// for the pipe_ctrl_decode slice.
package ctrl_pkg;

    localparam logic [3:0] OP_RTYPE  = 4'b0001;
    localparam logic [3:0] OP_ITYPE  = 4'b0010;
    localparam logic [3:0] OP_BRANCH = 4'b1000;
    localparam logic [3:0] OP_JUMP   = 4'b0100;
    localparam logic [3:0] OP_LOAD   = 4'b1100;
    localparam logic [3:0] OP_STORE  = 4'b0011;

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    // ALU op is kept outside the struct so its width can follow FUNCT_W.
    typedef struct packed {
        logic reg_dst;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode/funct -> control bundle decode; unknown opcodes
// decode to an all-zero NOP bundle with illegal_o raised.
module ctrl_decode_rom
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int FUNCT_W = 4
) (
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output ctrl_t              ctrl_o,
    output logic [FUNCT_W-1:0] alu_op_o,
    output logic               illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        alu_op_o  = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_W'(OP_RTYPE): begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                alu_op_o         = funct_i;
            end
            OPC_W'(OP_ITYPE): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                alu_op_o         = funct_i;
            end
            OPC_W'(OP_BRANCH): begin
                ctrl_o.branch = 1'b1;
                alu_op_o      = FUNCT_W'(ALU_SUB);
            end
            OPC_W'(OP_JUMP): begin
                ctrl_o.jump    = 1'b1;
                ctrl_o.alu_src = 1'b1;
            end
            OPC_W'(OP_LOAD): begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                alu_op_o          = FUNCT_W'(ALU_ADD);
            end
            OPC_W'(OP_STORE): begin
                ctrl_o.mem_write = 1'b1;
                alu_op_o         = FUNCT_W'(ALU_ADD);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_decode.sv
// Registered decode stage with valid/ready handshake and load-use bubble.
// Define CTRL_STALL_COUNT_EN to build the saturating stall_count counter.
module pipe_ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 24,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 4,
    parameter int FUNCT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               reg_dst,
    output logic               jump,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               alu_src,
    output logic               reg_write,
    output logic [FUNCT_W-1:0] alu_op,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rt,
    output logic [REG_AW-1:0]  rd,
    output logic [REG_AW-1:0]  dst_reg,
    output logic               illegal,
    output logic [15:0]        stall_count
);

    localparam int RS_LSB = INSTR_W - OPC_W - REG_AW;
    localparam int RT_LSB = RS_LSB - REG_AW;
    localparam int RD_LSB = RT_LSB - REG_AW;
    localparam int SPARE  = RD_LSB - FUNCT_W;

    logic [OPC_W-1:0]   in_opc;
    logic [REG_AW-1:0]  in_rs, in_rt, in_rd, in_dst;
    ctrl_t              dec_ctrl;
    logic [FUNCT_W-1:0] dec_alu;
    logic               dec_ill, rt_used, hazard, accept;

    state_t             state_q;
    logic               out_valid_q, illegal_q;
    ctrl_t              ctrl_q;
    logic [FUNCT_W-1:0] alu_q;
    logic [OPC_W-1:0]   opc_q;
    logic [REG_AW-1:0]  rs_q, rt_q, rd_q, dst_q;

    assign in_opc = instr[INSTR_W-1 -: OPC_W];
    assign in_rs  = instr[RS_LSB +: REG_AW];
    assign in_rt  = instr[RT_LSB +: REG_AW];
    assign in_rd  = instr[RD_LSB +: REG_AW];

    generate
        if (SPARE > 0) begin : g_spare
            logic unused_spare;
            assign unused_spare = ^instr[FUNCT_W +: SPARE];
        end
    endgenerate

    ctrl_decode_rom #(.OPC_W(OPC_W), .FUNCT_W(FUNCT_W)) u_rom (
        .opcode_i  (in_opc),
        .funct_i   (instr[FUNCT_W-1:0]),
        .ctrl_o    (dec_ctrl),
        .alu_op_o  (dec_alu),
        .illegal_o (dec_ill)
    );

    assign in_dst  = dec_ctrl.reg_dst ? in_rd : in_rt;
    assign rt_used = (in_opc == OPC_W'(OP_RTYPE)) || (in_opc == OPC_W'(OP_BRANCH)) ||
                     (in_opc == OPC_W'(OP_STORE));
    // Only a load still sitting in the output register can cause a load-use stall.
    assign hazard  = out_valid_q && ctrl_q.mem_read && in_valid &&
                     ((dst_q == in_rs) || (rt_used && (dst_q == in_rt)));
    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            alu_q       <= '0;
            opc_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            dst_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= dec_ctrl;
                alu_q       <= dec_alu;
                opc_q       <= in_opc;
                rs_q        <= in_rs;
                rt_q        <= in_rt;
                rd_q        <= in_rd;
                dst_q       <= in_dst;
                illegal_q   <= dec_ill;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                RUN:     if (hazard && out_ready) state_q <= BUBBLE;
                BUBBLE:  state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef CTRL_STALL_COUNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (((state_q == BUBBLE) || (in_valid && !in_ready)) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign out_valid  = out_valid_q;
    assign reg_dst    = ctrl_q.reg_dst;
    assign jump       = ctrl_q.jump;
    assign branch     = ctrl_q.branch;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign mem_write  = ctrl_q.mem_write;
    assign alu_src    = ctrl_q.alu_src;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_op     = alu_q;
    assign opcode     = opc_q;
    assign rs         = rs_q;
    assign rt         = rt_q;
    assign rd         = rd_q;
    assign dst_reg    = dst_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_decode.sv
// Scoreboard bench for pipe_ctrl_decode: expected bundles are queued on
// accept and compared while held on the output; in_ready is re-modelled.
module tb_pipe_ctrl_decode;

    typedef struct packed {
        logic [7:0] ctl;   // reg_dst,jump,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write
        logic [3:0] alu;
        logic [3:0] opc;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [3:0] dst;
        logic       ill;
    } exp_t;

`ifdef CTRL_STALL_COUNT_EN
    localparam logic [15:0] EXP_STALL = 16'd1;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [23:0] instr;
    logic        reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [3:0]  alu_op, opcode, rs, rt, rd, dst_reg;
    logic        illegal;
    logic [15:0] stall_count;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t f;
    logic hz;
    logic [32:0] obs;

    always #5 clk = ~clk;

    pipe_ctrl_decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_dst(reg_dst), .jump(jump), .branch(branch), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .alu_op(alu_op), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .dst_reg(dst_reg), .illegal(illegal), .stall_count(stall_count)
    );

    assign obs = {reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
                  alu_op, opcode, rs, rt, rd, dst_reg, illegal};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [23:0] w);
        exp_t e;
        e = '0;
        e.opc = w[23:20];
        e.rs  = w[19:16];
        e.rt  = w[15:12];
        e.rd  = w[11:8];
        case (w[23:20])
            4'h1: begin e.ctl = 8'b1000_0001; e.alu = w[3:0]; end
            4'h2: begin e.ctl = 8'b0000_0011; e.alu = w[3:0]; end
            4'h8: begin e.ctl = 8'b0010_0000; e.alu = 4'h2; end
            4'h4: begin e.ctl = 8'b0100_0010; e.alu = 4'h0; end
            4'hC: begin e.ctl = 8'b0001_1001; e.alu = 4'h1; end
            4'h3: begin e.ctl = 8'b0000_0100; e.alu = 4'h1; end
            default: e.ill = 1'b1;
        endcase
        e.dst = e.ctl[7] ? e.rd : e.rt;
        return e;
    endfunction

    // Scoreboard: out_valid mirrors queue occupancy (at most one in flight).
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            hz = 1'b0;
            if (q.size() != 0) begin
                f = q[0];
                chk("bundle", 64'(obs), 64'(f));
                hz = f.ctl[4] && in_valid &&
                     ((f.dst == instr[19:16]) ||
                      ((f.dst == instr[15:12]) &&
                       (instr[23:20] == 4'h1 || instr[23:20] == 4'h8 || instr[23:20] == 4'h3)));
            end
            chk("in_ready", 64'(in_ready), 64'(((q.size() == 0) || out_ready) && !hz));
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(instr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic send(input logic [23:0] w);
        int  n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        instr = w;
        forever begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 64'(n), 64'(0));
                break;
            end
        end
        in_valid = ($urandom_range(0, 2) == 0) ? 1'b0 : in_valid;
        if (!in_valid) cyc();
    endtask

    logic [23:0] stream [12] = '{24'hC56000, 24'hC67000, 24'h177801, 24'h863002,
                                 24'hC12000, 24'h352000, 24'hC12000, 24'h232007,
                                 24'h4000FF, 24'hF12345, 24'h2BCD03, 24'h1234A7};

    initial begin
        rst = 1'b1; in_valid = 1'b1; instr = 24'h123401; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({out_valid, obs, stall_count}), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("first_fields", 64'({reg_dst, reg_write, alu_op, rs, rt, rd, dst_reg}),
            64'({1'b1, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h4}));

        // back-pressure
        cyc();
        in_valid = 1'b1; instr = 24'h1A2B05;
        cyc();
        out_ready = 1'b0; instr = 24'h2789A5;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_hold", 64'({out_valid, opcode, alu_op, rd}), 64'({1'b1, 4'h1, 4'h5, 4'hB}));
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next", 64'({out_valid, opcode, alu_src}), 64'({1'b1, 4'h2, 1'b1}));

        // load-use bubble
        do_reset();
        in_valid = 1'b1; instr = 24'hC56000;
        cyc();
        instr = 24'h163701;
        @(negedge clk);
        chk("lu_stall_rdy", 64'(in_ready), 64'(0));
        cyc();
        @(negedge clk);
        chk("lu_bubble", 64'(out_valid), 64'(0));
        chk("lu_stall_cnt", 64'(stall_count), 64'(EXP_STALL));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lu_rtype", 64'({out_valid, opcode, rd}), 64'({1'b1, 4'h1, 4'h7}));

        // load then independent R-type
        cyc();
        in_valid = 1'b1; instr = 24'hC56000;
        cyc();
        instr = 24'h123401;
        @(negedge clk);
        chk("nh_rdy", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("nh_follow", 64'({out_valid, opcode, dst_reg}), 64'({1'b1, 4'h1, 4'h4}));

        // illegal opcode
        cyc();
        in_valid = 1'b1; instr = 24'hF00000;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("illegal", 64'({out_valid, illegal, obs[32:25], alu_op}),
            64'({1'b1, 1'b1, 8'h00, 4'h0}));

        // async reset in the middle of a bubble
        do_reset();
        in_valid = 1'b1; instr = 24'hC56000;
        cyc();
        instr = 24'h163701;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", 64'({out_valid, obs, stall_count}), 64'(0));
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));

        // mixed stream with random back-pressure, twice
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 12; i++) send(stream[i]);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() != 0; k++) cyc();
        chk("drain", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
